// File: rtl/instr_pkg.sv
// Shared LEGv8 encoding constants and field helpers for fetch, decode and the bench.
// Fetch itself only needs the B opcode and the halt word. The other slices are kept here so all users share one encoding.
package instr_pkg;

    localparam int          ADDR_W        = 16;
    localparam logic [31:0] HALT_WORD_DEF = 32'hD60003E0;

    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [10:0] OPC_BR   = 11'b11010110000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [8:0]  OPC_MOVZ = 9'b110100101;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef enum logic [3:0] {
        CLS_B, CLS_BR, CLS_ADDI, CLS_SUBI, CLS_LDUR,
        CLS_STUR, CLS_ADD, CLS_MOVZ, CLS_OTHER
    } instr_class_e;

    // Opcode fields by format: B (6 bits), I (10), IW (9), R/D (11).
    function automatic logic [5:0] opc_b_field(input logic [31:0] w);
        return w[31:26];
    endfunction

    function automatic logic [9:0] opc_i_field(input logic [31:0] w);
        return w[31:22];
    endfunction

    function automatic logic [8:0] opc_iw_field(input logic [31:0] w);
        return w[31:23];
    endfunction

    function automatic logic [10:0] opc_r_field(input logic [31:0] w);
        return w[31:21];
    endfunction

    function automatic logic [25:0] imm26_field(input logic [31:0] w);
        return w[25:0];
    endfunction

    function automatic instr_class_e classify(input logic [31:0] w);
        instr_class_e c;
        c = CLS_OTHER;
        if (opc_b_field(w) == OPC_B)
            c = CLS_B;
        else if (opc_r_field(w) == OPC_BR)
            c = CLS_BR;
        else if (opc_i_field(w) == OPC_ADDI)
            c = CLS_ADDI;
        else if (opc_i_field(w) == OPC_SUBI)
            c = CLS_SUBI;
        else if (opc_r_field(w) == OPC_LDUR)
            c = CLS_LDUR;
        else if (opc_r_field(w) == OPC_STUR)
            c = CLS_STUR;
        else if (opc_r_field(w) == OPC_ADD)
            c = CLS_ADD;
        else if (opc_iw_field(w) == OPC_MOVZ)
            c = CLS_MOVZ;
        return c;
    endfunction

endpackage

// File: rtl/branch_predecode.sv
// Combinational predecode of the fetched word.
// It flags B and the halt word and computes the PC that fetch uses next.
module branch_predecode #(
    parameter int          ADDR_W    = instr_pkg::ADDR_W,
    parameter logic [31:0] HALT_WORD = instr_pkg::HALT_WORD_DEF
) (
    input  logic [31:0]       rom_data,
    input  logic [ADDR_W-1:0] pc,
    output logic              is_b,
    output logic              is_halt,
    output logic [ADDR_W-1:0] next_pc
);

    import instr_pkg::OPC_B;
    import instr_pkg::opc_b_field;
    import instr_pkg::imm26_field;

    logic signed [63:0] imm_sext;
    logic [ADDR_W-1:0]  imm_trunc;

    // Sign-extend first, then keep the low bits. This gives PC-relative arithmetic modulo 2^ADDR_W.
    assign imm_sext  = {{38{rom_data[25]}}, imm26_field(rom_data)};
    assign imm_trunc = imm_sext[ADDR_W-1:0];

    assign is_b    = (opc_b_field(rom_data) == OPC_B);
    assign is_halt = (rom_data == HALT_WORD);
    assign next_pc = is_b ? (pc + imm_trunc) : (pc + ADDR_W'(1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch front end. It holds the PC register, the run/halt state, the one-entry decode buffer and the handshake counter.
module instr_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [31:0] HALT_WORD = 32'hD60003E0,
    parameter int          ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    import instr_pkg::fetch_state_e;
    import instr_pkg::ST_RUN;
    import instr_pkg::ST_HALT;

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              out_valid_q;
    logic [31:0]       out_instr_q;
    logic [ADDR_W-1:0] out_pc_q;
    logic              halted_q;
    logic [31:0]       fetch_count_q;

    logic              is_b;
    logic              is_halt;
    logic [ADDR_W-1:0] next_pc;
    logic              can_load;
    logic              handshake;

    branch_predecode #(
        .ADDR_W    (ADDR_W),
        .HALT_WORD (HALT_WORD)
    ) u_predecode (
        .rom_data (rom_data),
        .pc       (pc_q),
        .is_b     (is_b),
        .is_halt  (is_halt),
        .next_pc  (next_pc)
    );

    assign can_load  = !out_valid_q || out_ready;
    assign handshake = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC[ADDR_W-1:0];
            out_valid_q   <= 1'b0;
            out_instr_q   <= 32'd0;
            out_pc_q      <= '0;
            halted_q      <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            // The handshake count does not depend on the priority chain below.
            if (handshake)
                fetch_count_q <= fetch_count_q + 32'd1;

            if (redirect_valid) begin
                pc_q        <= redirect_pc;
                out_valid_q <= 1'b0;
                state_q     <= ST_RUN;
                halted_q    <= 1'b0;
            end else if (state_q == ST_HALT) begin
                if (out_ready)
                    out_valid_q <= 1'b0;
            end else if (can_load) begin
                if (is_halt) begin
                    state_q     <= ST_HALT;
                    halted_q    <= 1'b1;
                    out_valid_q <= 1'b0;
                end else begin
                    // B still goes to decode, which treats it as a NOP.
                    out_instr_q <= rom_data;
                    out_pc_q    <= pc_q;
                    out_valid_q <= 1'b1;
                    pc_q        <= next_pc;
                end
            end
        end
    end

    assign rom_addr    = pc_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. It uses a copy-loop ROM, a halt ROM and a second instance reset to 16'hFFFF for the wrap cases.
module tb_instr_fetch;

    localparam logic [31:0] NOP_W  = 32'hD503201F;
    localparam logic [31:0] HALT_W = 32'hD60003E0;
    localparam logic [31:0] B_M1   = 32'h17FFFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rom_addr, out_pc, redirect_pc;
    logic [31:0] rom_data, out_instr, fetch_count;
    logic        out_valid, out_ready, redirect_valid, halted;

    logic [15:0] rom2_addr, out2_pc;
    logic [31:0] rom2_data, out2_instr, fetch2_count;
    logic        out2_valid, halted2;

    logic [31:0] rom [0:15];
    logic [31:0] copy_prog [0:15];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign rom_data  = (rom_addr < 16'd16) ? rom[rom_addr[3:0]] : NOP_W;
    assign rom2_data = (rom2_addr == 16'h0000) ? B_M1 : NOP_W;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    instr_fetch #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom2_addr),
        .rom_data       (rom2_data),
        .out_valid      (out2_valid),
        .out_ready      (1'b1),
        .out_instr      (out2_instr),
        .out_pc         (out2_pc),
        .redirect_valid (1'b0),
        .redirect_pc    (16'h0000),
        .halted         (halted2),
        .fetch_count    (fetch2_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse ends before the next edge. The reset state is checked right after it.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic load_copy();
        for (int i = 0; i < 16; i++) rom[i] = copy_prog[i];
    endtask

    task automatic load_halt();
        load_copy();
        rom[3] = HALT_W;
    endtask

    int exp_seq [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 2, 3, 4, 5};

    initial begin
        copy_prog[0] = 32'hD2800021;
        copy_prog[1] = 32'hD2800404;
        copy_prog[2] = 32'hF8400025;
        copy_prog[3] = 32'hF8000045;
        copy_prog[4] = 32'hD1000484;
        copy_prog[5] = 32'h91002021;
        copy_prog[6] = 32'h91002042;
        copy_prog[7] = 32'h8B0500C6;
        copy_prog[8] = 32'hD2800000;
        copy_prog[9] = 32'h17FFFFF9;
        for (int i = 10; i < 16; i++) copy_prog[i] = NOP_W;

        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;

        // 1: copy loop with out_ready held high
        load_copy();
        do_reset();
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_addr", {16'd0, rom_addr}, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_count", fetch_count, 32'd0);
        check_eq("rst_instr", out_instr, 32'd0);
        for (int k = 0; k < 14; k++) begin
            step();
            check_eq($sformatf("loop_pc[%0d]", k), {16'd0, out_pc}, exp_seq[k]);
            check_eq($sformatf("loop_valid[%0d]", k), {31'd0, out_valid}, 32'd1);
            if (k == 0) check_eq("instr_pc0", out_instr, 32'hD2800021);
            if (k == 9) begin
                check_eq("instr_pc9", out_instr, 32'h17FFFFF9);
                check_eq("b_target", {16'd0, rom_addr}, 32'd2);
            end
        end
        check_eq("loop_count", fetch_count, 32'd13);

        // 2: stall while out_pc = 4
        do_reset();
        for (int k = 0; k < 5; k++) step();
        check_eq("pre_stall_pc", {16'd0, out_pc}, 32'd4);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq($sformatf("stall_instr[%0d]", k), out_instr, 32'hD1000484);
            check_eq($sformatf("stall_pc[%0d]", k), {16'd0, out_pc}, 32'd4);
            check_eq($sformatf("stall_addr[%0d]", k), {16'd0, rom_addr}, 32'd5);
            check_eq($sformatf("stall_valid[%0d]", k), {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        step();
        check_eq("release_pc", {16'd0, out_pc}, 32'd5);
        step();
        check_eq("release_pc2", {16'd0, out_pc}, 32'd6);

        // 3: halt word at address 3
        load_halt();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq($sformatf("halt_run_pc[%0d]", k), {16'd0, out_pc}, k);
        end
        step();
        check_eq("halt_flag", {31'd0, halted}, 32'd1);
        check_eq("halt_addr", {16'd0, rom_addr}, 32'd3);
        check_eq("halt_valid", {31'd0, out_valid}, 32'd0);
        check_eq("halt_count", fetch_count, 32'd3);
        step();
        check_eq("halt_addr_hold", {16'd0, rom_addr}, 32'd3);
        check_eq("halt_valid_hold", {31'd0, out_valid}, 32'd0);

        // 4a: redirect flushes a stalled entry
        load_copy();
        do_reset();
        for (int k = 0; k < 4; k++) step();
        check_eq("pre_redir_pc", {16'd0, out_pc}, 32'd3);
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0007;
        step();
        redirect_valid = 1'b0;
        check_eq("redir_flush", {31'd0, out_valid}, 32'd0);
        check_eq("redir_addr", {16'd0, rom_addr}, 32'd7);
        check_eq("redir_count", fetch_count, 32'd3);
        out_ready = 1'b1;
        step();
        check_eq("redir_next_pc", {16'd0, out_pc}, 32'd7);
        check_eq("redir_next_instr", out_instr, 32'h8B0500C6);

        // 4b: redirect out of HALT
        load_halt();
        do_reset();
        for (int k = 0; k < 4; k++) step();
        check_eq("pre_redir_halt", {31'd0, halted}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0007;
        step();
        redirect_valid = 1'b0;
        check_eq("redir_unhalt", {31'd0, halted}, 32'd0);
        check_eq("redir_halt_addr", {16'd0, rom_addr}, 32'd7);
        step();
        check_eq("resume_pc", {16'd0, out_pc}, 32'd7);
        check_eq("resume_valid", {31'd0, out_valid}, 32'd1);

        // 5: wrap instance, reset at 16'hFFFF with B -1 at 16'h0000
        do_reset();
        check_eq("wrap_rst_addr", {16'd0, rom2_addr}, 32'h0000FFFF);
        step();
        check_eq("wrap_pc_ffff", {16'd0, out2_pc}, 32'h0000FFFF);
        check_eq("wrap_addr0", {16'd0, rom2_addr}, 32'd0);
        step();
        check_eq("wrap_pc_0", {16'd0, out2_pc}, 32'd0);
        check_eq("wrap_b_instr", out2_instr, B_M1);
        check_eq("wrap_b_target", {16'd0, rom2_addr}, 32'h0000FFFF);

        // 6: asynchronous reset in the middle of a cycle
        load_copy();
        do_reset();
        for (int k = 0; k < 3; k++) step();
        check_eq("pre_arst_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #2;
        check_eq("arst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("arst_count", fetch_count, 32'd0);
        check_eq("arst_halted", {31'd0, halted}, 32'd0);
        check_eq("arst_addr", {16'd0, rom_addr}, 32'd0);
        rst_n = 1'b1;
        load_halt();
        do_reset();
        for (int k = 0; k < 4; k++) step();
        check_eq("pre_arst2_halted", {31'd0, halted}, 32'd1);
        rst_n = 1'b0;
        #2;
        check_eq("arst2_halted", {31'd0, halted}, 32'd0);
        check_eq("arst2_count", fetch_count, 32'd0);
        rst_n = 1'b1;
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
